// File: rtl/door_lock_pkg.sv
// Shared types and defaults for the door-lock guard stage.
package door_lock_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RELEASE = 2'd1,
      LOCKOUT = 2'd2
   } guard_state_t;

   localparam int unsigned HOLD_CYCLES_DEF    = 16;
   localparam int unsigned MAX_FAILS_DEF      = 3;
   localparam int unsigned LOCKOUT_CYCLES_DEF = 64;

   // Width needed to hold the longer of the two timed windows.
   function automatic int unsigned tmr_width(input int unsigned hold, input int unsigned lock);
      int unsigned m;
      m = (hold > lock) ? hold : lock;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/door_lock_guard_if.sv
// Signal bundle between the password FSM / actuators and the door-lock guard.
// Optional door_open sensor exists only when DOOR_FORCED_ALARM_EN is defined.
interface door_lock_guard_if;
   logic       unlock_in;
   logic       error_in;
   logic       solenoid;
   logic       locked_out;
   logic       alarm;
   logic [3:0] fail_count;
`ifdef DOOR_FORCED_ALARM_EN
   logic       door_open;

   modport master (
      output unlock_in, error_in, door_open,
      input  solenoid, locked_out, alarm, fail_count
   );
   modport slave (
      input  unlock_in, error_in, door_open,
      output solenoid, locked_out, alarm, fail_count
   );
`else
   modport master (
      output unlock_in, error_in,
      input  solenoid, locked_out, alarm, fail_count
   );
   modport slave (
      input  unlock_in, error_in,
      output solenoid, locked_out, alarm, fail_count
   );
`endif
endinterface

// File: rtl/door_lock_guard_timer.sv
// Loadable down-counter shared by the RELEASE and LOCKOUT windows; holds at zero.
module guard_timer #(
   parameter int unsigned W = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] r_value;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_value <= '0;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (r_value != '0) begin
         r_value <= r_value - 1'b1;
      end
   end

   assign o_zero = (r_value == '0);

endmodule

// File: rtl/door_lock_guard.sv
// Door-lock guard: timed solenoid release, consecutive-failure lockout and alarm.
// Build option DOOR_FORCED_ALARM_EN adds a sticky forced-door alarm from door_open.
module door_lock_guard
   import door_lock_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
   parameter int unsigned MAX_FAILS      = MAX_FAILS_DEF,
   parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset,
   door_lock_guard_if.slave   bus
);

   localparam int unsigned TMR_W = tmr_width(HOLD_CYCLES, LOCKOUT_CYCLES);
   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [4:0]       MAX_F5    = 5'(MAX_FAILS);

   guard_state_t     r_state, w_state_d;
   logic [3:0]       r_fail, w_fail_d;
   logic             r_unlock_q, r_error_q;
   logic             r_solenoid, r_locked_out, r_alarm;
   logic             w_unlock_rise, w_error_rise;
   logic             w_tmr_load, w_tmr_zero;
   logic [TMR_W-1:0] w_tmr_val;
   logic [4:0]       w_fail_inc;
   logic             w_alarm_d;

   assign w_unlock_rise = bus.unlock_in & ~r_unlock_q;
   assign w_error_rise  = bus.error_in & ~r_error_q;
   assign w_fail_inc    = {1'b0, r_fail} + 5'd1;

   guard_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_zero     (w_tmr_zero)
   );

   always_comb begin
      w_state_d  = r_state;
      w_fail_d   = r_fail;
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      unique case (r_state)
         IDLE, RELEASE: begin
            // Error beats a simultaneous unlock so a bad entry never opens the door.
            if (w_error_rise) begin
               if (w_fail_inc < MAX_F5) begin
                  w_state_d = IDLE;
                  w_fail_d  = w_fail_inc[3:0];
               end else begin
                  w_state_d  = LOCKOUT;
                  w_fail_d   = MAX_F5[3:0];
                  w_tmr_load = 1'b1;
                  w_tmr_val  = LOCK_LOAD;
               end
            end else if (w_unlock_rise) begin
               w_state_d  = RELEASE;
               w_tmr_load = 1'b1;
               w_tmr_val  = HOLD_LOAD;
               if (r_state == IDLE) w_fail_d = '0;
            end else if (r_state == RELEASE && w_tmr_zero) begin
               w_state_d = IDLE;
            end
         end
         LOCKOUT: begin
            if (w_tmr_zero) begin
               w_state_d = IDLE;
               w_fail_d  = '0;
            end
         end
         default: begin
            w_state_d = IDLE;
            w_fail_d  = '0;
         end
      endcase
   end

`ifdef DOOR_FORCED_ALARM_EN
   logic r_forced, w_forced_d;

   // Door movement outside a release wins over a same-cycle unlock clear.
   always_comb begin
      w_forced_d = r_forced;
      if (w_state_d == RELEASE && r_state != RELEASE) w_forced_d = 1'b0;
      if (bus.door_open && r_state != RELEASE) w_forced_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_forced <= 1'b0;
      else       r_forced <= w_forced_d;
   end

   assign w_alarm_d = (w_state_d == LOCKOUT) | w_forced_d;
`else
   assign w_alarm_d = (w_state_d == LOCKOUT);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_fail       <= '0;
         r_unlock_q   <= 1'b0;
         r_error_q    <= 1'b0;
         r_solenoid   <= 1'b0;
         r_locked_out <= 1'b0;
         r_alarm      <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_fail       <= w_fail_d;
         r_unlock_q   <= bus.unlock_in;
         r_error_q    <= bus.error_in;
         r_solenoid   <= (w_state_d == RELEASE);
         r_locked_out <= (w_state_d == LOCKOUT);
         r_alarm      <= w_alarm_d;
      end
   end

   assign bus.solenoid   = r_solenoid;
   assign bus.locked_out = r_locked_out;
   assign bus.alarm      = r_alarm;
   assign bus.fail_count = r_fail;

endmodule

// File: tb/tb_door_lock_guard.sv
// Randomised and directed bench for door_lock_guard against a cycle-count reference model.
module tb_door_lock_guard;

   localparam int HOLD = 16;
   localparam int MAXF = 3;
   localparam int LOCK = 64;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   door_lock_guard_if u_if ();

   door_lock_guard u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: remaining window lengths and failure count.
   int rel_left, lock_left, fails;
   bit pu, pe, forced, door;

   function automatic logic [6:0] exp_vec();
      logic a;
      a = (lock_left > 0) || forced;
      return {rel_left > 0, lock_left > 0, a, 4'(fails)};
   endfunction

   function automatic logic [6:0] got_vec();
      return {u_if.solenoid, u_if.locked_out, u_if.alarm, u_if.fail_count};
   endfunction

   task automatic model_reset();
      rel_left = 0; lock_left = 0; fails = 0; pu = 0; pe = 0; forced = 0;
   endtask

   task automatic model_edge(input bit u, input bit e);
      bit ur, er, was_rel;
      ur = u && !pu;
      er = e && !pe;
      was_rel = rel_left > 0;
      pu = u;
      pe = e;
      if (lock_left > 0) begin
         lock_left--;
         if (lock_left == 0) fails = 0;
      end else if (er) begin
         fails++;
         rel_left = 0;
         if (fails >= MAXF) begin
            fails = MAXF;
            lock_left = LOCK;
         end
      end else if (ur) begin
         if (!was_rel) fails = 0;
         rel_left = HOLD;
      end else if (rel_left > 0) begin
         rel_left--;
      end
`ifdef DOOR_FORCED_ALARM_EN
      if (!was_rel && rel_left > 0) forced = 0;
      if (door && !was_rel) forced = 1;
`endif
   endtask

   // One clock: drive inputs, take the edge, advance model, sample 1ns later.
   task automatic step(input bit u, input bit e, output logic [6:0] got, output logic [6:0] exp);
      u_if.unlock_in = u;
      u_if.error_in  = e;
`ifdef DOOR_FORCED_ALARM_EN
      u_if.door_open = door;
`endif
      @(posedge clk);
      model_edge(u, e);
      #1;
      got = got_vec();
      exp = exp_vec();
   endtask

   task automatic do_reset();
      u_if.unlock_in = 0;
      u_if.error_in  = 0;
      door = 0;
`ifdef DOOR_FORCED_ALARM_EN
      u_if.door_open = 0;
`endif
      reset = 1;
      #3;
      model_reset();
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      logic [6:0] g;
      do_reset();
      g = got_vec();
      n_chk++;
      if (g !== 7'b0) begin
         n_fail++;
         $display("FAIL reset outputs got %b exp %b", g, 7'b0);
      end
   endtask

   task automatic test_unlock();
      logic [6:0] g, x;
      int high, first;
      do_reset();
      high = 0; first = -1;
      for (int i = 0; i < 24; i++) begin
         step(i == 0, 0, g, x);
         if (g[6]) begin high++; if (first < 0) first = i; end
         n_chk++;
         if (g !== x) begin n_fail++; $display("FAIL unlock cyc %0d got %b exp %b", i, g, x); end
      end
      n_chk++;
      if (high != HOLD || first != 0 || g[3:0] !== 4'd0) begin
         n_fail++;
         $display("FAIL unlock_len got %0d first %0d exp %0d first 0", high, first, HOLD);
      end
   endtask

   task automatic test_fail_sequence();
      logic [6:0] g, x;
      logic [3:0] want [3];
      want[0] = 4'd1; want[1] = 4'd2; want[2] = 4'd0;
      do_reset();
      for (int s = 0; s < 3; s++) begin
         step(s == 2, s != 2, g, x);
         n_chk++;
         if (g !== x || g[3:0] !== want[s]) begin
            n_fail++;
            $display("FAIL fail_seq %0d got %b exp %b count %0d", s, g, x, want[s]);
         end
         for (int i = 0; i < 5; i++) step(0, 0, g, x);
      end
      n_chk++;
      if (g[6] !== 1'b1 || g[5] !== 1'b0) begin
         n_fail++;
         $display("FAIL fail_seq_open got sol %b lock %b exp 1 0", g[6], g[5]);
      end
   endtask

   task automatic test_lockout();
      logic [6:0] g, x;
      int locked;
      do_reset();
      for (int s = 0; s < 2; s++) begin
         step(0, 1, g, x);
         step(0, 0, g, x);
      end
      locked = 0;
      for (int i = 0; i < 80; i++) begin
         step(i == 10, i == 0, g, x);
         if (g[5]) begin
            locked++;
            n_chk++;
            if (g !== {1'b0, 1'b1, 1'b1, 4'd3}) begin
               n_fail++; $display("FAIL lockout_out cyc %0d got %b exp %b", i, g, 7'b0110011);
            end
         end
         n_chk++;
         if (g !== x) begin n_fail++; $display("FAIL lockout cyc %0d got %b exp %b", i, g, x); end
      end
      n_chk++;
      if (locked != LOCK || g !== 7'b0) begin
         n_fail++; $display("FAIL lockout_len got %0d end %b exp %0d end 0", locked, g, LOCK);
      end
   endtask

   task automatic test_simultaneous_and_abort();
      logic [6:0] g, x;
      do_reset();
      step(1, 1, g, x);
      n_chk++;
      if (g !== 7'b0000001 || g !== x) begin
         n_fail++; $display("FAIL simult got %b exp %b", g, 7'b0000001);
      end
      step(0, 0, g, x);
      step(1, 0, g, x);
      for (int i = 0; i < 4; i++) step(0, 0, g, x);
      step(0, 1, g, x);
      n_chk++;
      if (g !== 7'b0000001 || g !== x) begin
         n_fail++; $display("FAIL abort got %b exp %b", g, 7'b0000001);
      end
   endtask

   task automatic test_held_and_extend();
      logic [6:0] g, x;
      int high;
      do_reset();
      high = 0;
      for (int i = 0; i < 50; i++) begin
         step(i < 40, 0, g, x);
         if (g[6]) high++;
         n_chk++;
         if (g !== x) begin n_fail++; $display("FAIL held cyc %0d got %b exp %b", i, g, x); end
      end
      n_chk++;
      if (high != HOLD) begin n_fail++; $display("FAIL held_len got %0d exp %0d", high, HOLD); end
      high = 0;
      for (int i = 0; i < 33; i++) begin
         step(i == 0 || i == 12, 0, g, x);
         if (g[6]) high++;
      end
      n_chk++;
      if (high != 12 + HOLD) begin
         n_fail++; $display("FAIL extend_len got %0d exp %0d", high, 12 + HOLD);
      end
   endtask

   task automatic test_reset_mid_lockout();
      logic [6:0] g, x;
      do_reset();
      for (int s = 0; s < MAXF; s++) begin
         step(0, 1, g, x);
         step(0, 0, g, x);
      end
      for (int i = 0; i < 5; i++) step(0, 0, g, x);
      reset = 1;
      #1;
      g = got_vec();
      n_chk++;
      if (g !== 7'b0 || x[5] !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid got %b exp %b (pre %b)", g, 7'b0, x);
      end
      model_reset();
      @(negedge clk);
      reset = 0;
   endtask

`ifdef DOOR_FORCED_ALARM_EN
   task automatic test_forced();
      logic [6:0] g, x;
      do_reset();
      door = 1;
      step(0, 0, g, x);
      door = 0;
      for (int i = 0; i < 100; i++) step(0, 0, g, x);
      n_chk++;
      if (g[4] !== 1'b1 || g !== x) begin n_fail++; $display("FAIL forced_hold got %b exp %b", g, x); end
      step(1, 0, g, x);
      n_chk++;
      if (g[4] !== 1'b0 || g !== x) begin n_fail++; $display("FAIL forced_clear got %b exp %b", g, x); end
   endtask
`endif

   task automatic test_random();
      logic [6:0] g, x;
      int bad;
      do_reset();
      bad = 0;
      for (int i = 0; i < 3000; i++) begin
         door = ($urandom_range(0, 40) == 0);
         step($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, g, x);
         n_chk++;
         if (g !== x) begin
            n_fail++;
            bad++;
            if (bad < 10) $display("FAIL random cyc %0d got %b exp %b", i, g, x);
         end
      end
      door = 0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      reset = 1;
      u_if.unlock_in = 0;
      u_if.error_in = 0;
      door = 0;
      model_reset();
      test_reset();
      test_unlock();
      test_fail_sequence();
      test_lockout();
      test_simultaneous_and_abort();
      test_held_and_extend();
      test_reset_mid_lockout();
`ifdef DOOR_FORCED_ALARM_EN
      test_forced();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
